// File: rtl/uadd_arb_pkg.sv
// Shared types and constants for the two-requester unsigned adder arbiter.
package uadd_arb_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned ID_W      = 1;
    localparam int unsigned NUM_REQ   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/uadd_arbiter_if.sv
// Requester/response bundle for uadd_arbiter; slave = the arbiter, master = the environment.
interface uadd_arbiter_if #(
    parameter int unsigned WIDTH = uadd_arb_pkg::WIDTH_DEF
);

    logic                              req0_valid;
    logic                              req0_ready;
    logic [WIDTH-1:0]                  req0_a;
    logic [WIDTH-1:0]                  req0_b;
    logic                              req1_valid;
    logic                              req1_ready;
    logic [WIDTH-1:0]                  req1_a;
    logic [WIDTH-1:0]                  req1_b;
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [WIDTH-1:0]                  rsp_sum;
    logic                              rsp_carry;
    logic [uadd_arb_pkg::ID_W-1:0]     rsp_id;
    logic                              sel;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_carry, rsp_id, sel
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_carry, rsp_id, sel
    );

endinterface

// File: rtl/uadd_rr_arbiter.sv
// Two-requester grant logic: round-robin when UADD_ARB_RR_EN is defined, else fixed priority to requester 0.
module uadd_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef UADD_ARB_RR_EN
    // Remembers which requester was granted last; reset value lets requester 0 win first.
    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{clk, rst_n, accept};

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/uadd_arbiter.sv
// Arbitrated unsigned adder: accepts one operand pair in IDLE, adds in EXEC, holds the result in RESP.
// Build with UADD_ARB_RR_EN defined for round-robin arbitration; default is fixed priority.
module uadd_arbiter
    import uadd_arb_pkg::*;
#(
    parameter int unsigned WIDTH = uadd_arb_pkg::WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uadd_arbiter_if.slave bus
);

    state_t            state;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_q;
    logic              sel_mux;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH:0]    sum_full;
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_sum_q;
    logic              rsp_carry_q;
    logic [ID_W-1:0]   rsp_id_q;

    assign req    = {bus.req1_valid, bus.req0_valid};
    assign accept = rst_n && (state == IDLE) && (|req);

    uadd_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // Readys are only ever seen in the accept cycle; sel follows the live grant there, else the last grant.
    assign bus.req0_ready = accept & grant[0];
    assign bus.req1_ready = accept & grant[1];
    assign sel_mux        = accept ? grant[1] : sel_q;
    assign bus.sel        = sel_mux;

    assign op_a     = sel_mux ? bus.req1_a : bus.req0_a;
    assign op_b     = sel_mux ? bus.req1_b : bus.req0_b;
    assign sum_full = (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        sel_q    <= grant[1];
                        rsp_id_q <= ID_W'(grant[1]);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_q   <= sum_full[WIDTH-1:0];
                    rsp_carry_q <= sum_full[WIDTH];
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_uadd_arbiter.sv
// Scoreboard bench for uadd_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_uadd_arbiter;
    import uadd_arb_pkg::*;

    localparam int unsigned W = WIDTH_DEF;
`ifdef UADD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         id;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uadd_arbiter_if #(.WIDTH(W)) bus ();

    uadd_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    op_t  q0[$];
    op_t  q1[$];
    rsp_t sb[$];
    int   id_log[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = -100;
    int   last_gnt = 1;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;
    bit   rnd_ready = 1'b0;
    bit   rsp_rdy_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion (t=%0t)", name, $time);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Driver: presents each requester's queue head, retires it after an observed accept.
    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            acc0 = 1'b0;
            acc1 = 1'b0;
            bus.req0_valid = (q0.size() > 0);
            bus.req0_a     = (q0.size() > 0) ? q0[0].a : '0;
            bus.req0_b     = (q0.size() > 0) ? q0[0].b : '0;
            bus.req1_valid = (q1.size() > 0);
            bus.req1_a     = (q1.size() > 0) ? q1[0].a : '0;
            bus.req1_b     = (q1.size() > 0) ? q1[0].b : '0;
            bus.rsp_ready  = rnd_ready ? ($urandom_range(0, 3) != 0) : rsp_rdy_force;
        end
    end

    // Accept monitor: checks the grant against the arbitration rule and pushes the expected result.
    initial begin
        logic [1:0] v;
        int         exp_id;
        op_t        op;
        logic [W:0] s;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rsp_valid)
                    check("ready_while_busy", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
                if (bus.req0_ready || bus.req1_ready) begin
                    v = {bus.req1_valid, bus.req0_valid};
                    if (v == 2'b11)     exp_id = (RR && last_gnt == 0) ? 1 : 0;
                    else if (v == 2'b10) exp_id = 1;
                    else                 exp_id = 0;
                    check("grant", 64'({bus.req1_ready, bus.req0_ready}), (exp_id == 1) ? 64'd2 : 64'd1);
                    check("sel_grant", 64'(bus.sel), 64'(exp_id));
                    op = (exp_id == 1) ? q1[0] : q0[0];
                    s  = {1'b0, op.a} + {1'b0, op.b};
                    sb.push_back('{sum: s[W-1:0], carry: s[W], id: exp_id[0]});
                    id_log.push_back(exp_id);
                    last_gnt = exp_id;
                    acc_cyc  = cyc;
                    if (exp_id == 1) acc1 = 1'b1; else acc0 = 1'b1;
                end
            end
        end
    end

    // Response monitor: latency, hold-under-backpressure and scoreboard compare.
    initial begin
        logic         pv, prdy, pcar, pid;
        logic [W-1:0] psum;
        rsp_t         e;
        pv = 1'b0; prdy = 1'b0; pcar = 1'b0; pid = 1'b0; psum = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (bus.rsp_valid && !pv)
                    check("latency", 64'(cyc - acc_cyc), 64'd2);
                if (pv && !prdy)
                    check("hold", {29'd0, bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id},
                                  {29'd0, 1'b1, psum, pcar, pid});
                if (bus.rsp_valid)
                    check("sel_held", 64'(bus.sel), 64'(bus.rsp_id));
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got sum %0h id %0h expected no response", bus.rsp_sum, bus.rsp_id);
                    end else begin
                        e = sb.pop_front();
                        check("rsp", {30'd0, bus.rsp_sum, bus.rsp_carry, bus.rsp_id},
                                     {30'd0, e.sum, e.carry, e.id});
                    end
                end
                pv = bus.rsp_valid; prdy = bus.rsp_ready;
                psum = bus.rsp_sum; pcar = bus.rsp_carry; pid = bus.rsp_id;
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !bus.rsp_valid) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic apply_reset();
        sb.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        last_gnt = 1;
    endtask

    initial begin
        int   exp_ids[4];
        bit   seen;
        logic [W-1:0] ra, rb;

        // Reset state with a request already waiting.
        q0.push_back('{a: W'(32'h0000_0005), b: W'(32'h0000_0003)});
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
        check("rst_rsp_carry", 64'(bus.rsp_carry), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_sel",       64'(bus.sel),       64'd0);
        check("rst_readys",    64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        check("rst_req0_valid_seen", 64'(bus.req0_valid), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single request 5 + 3 on requester 0.
        @(negedge clk);
        check("single_ready", 64'(bus.req0_ready), 64'd1);
        wait_idle(50);

        // Overflow on requester 1.
        q1.push_back('{a: '1, b: W'(1)});
        wait_idle(50);

        // Contention with continuous valids.
        @(negedge clk);
        id_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{a: W'($urandom), b: W'($urandom)});
            q1.push_back('{a: W'($urandom), b: W'($urandom)});
        end
        wait_idle(200);
        exp_ids = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++)
            check("contention_id", (i < id_log.size()) ? 64'(id_log[i]) : 64'hdead, 64'(exp_ids[i]));

        // Backpressure: response held for 5 cycles while requester 0 waits.
        rsp_rdy_force = 1'b0;
        @(negedge clk);
        q1.push_back('{a: W'($urandom), b: W'($urandom)});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        if (!seen) fail_now("bp_rsp_valid");
        q0.push_back('{a: W'($urandom), b: W'($urandom)});
        repeat (5) begin
            @(negedge clk);
            check("bp_no_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        end
        rsp_rdy_force = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_ready && bus.rsp_valid) seen = 1'b1;
        end
        if (!seen) fail_now("bp_release");
        @(negedge clk);
        check("idle_after_rsp", 64'(bus.req0_ready), 64'd1);
        wait_idle(50);

        // Reset while the transaction is in EXEC.
        q0.push_back('{a: W'($urandom), b: W'($urandom)});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req0_ready) seen = 1'b1;
        end
        if (!seen) fail_now("exec_accept");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        apply_reset();
        check("exec_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("exec_rst_sel",   64'(bus.sel),       64'd0);
        repeat (2) @(negedge clk);
        check("exec_rst_hold", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ra = pick_operand();
        rb = pick_operand();
        q0.push_back('{a: ra, b: rb});
        wait_idle(50);

        // Randomized traffic with random consumer backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q0.size() < 3 && $urandom_range(0, 2) == 0)
                q0.push_back('{a: pick_operand(), b: pick_operand()});
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                q1.push_back('{a: pick_operand(), b: pick_operand()});
        end
        rnd_ready = 1'b0;
        rsp_rdy_force = 1'b1;
        wait_idle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uadd_arbiter.md
UADD_ARBITER -- requirements
Module: uadd_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/sum width in bits.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req0_valid  in  1  requester 0 has an operand pair.
REQ-005 SHALL have port: req0_ready  out  1  requester 0 transfer accepted this cycle.
REQ-006 SHALL have port: req0_a, req0_b  in  WIDTH each  requester 0 operands.
REQ-007 SHALL have port: req1_valid  in  1  requester 1 has an operand pair.
REQ-008 SHALL have port: req1_ready  out  1  requester 1 transfer accepted this cycle.
REQ-009 SHALL have port: req1_a, req1_b  in  WIDTH each  requester 1 operands.
REQ-010 SHALL have port: rsp_valid  out  1  result available.
REQ-011 SHALL have port: rsp_ready  in  1  consumer accepts result.
REQ-012 SHALL have port: rsp_sum  out  WIDTH  unsigned sum, modulo 2^WIDTH.
REQ-013 SHALL have port: rsp_carry  out  1  carry out of the unsigned add.
REQ-014 SHALL have port: rsp_id  out  1  index of the requester that owns the result.
REQ-015 SHALL have port: sel  out  1  operand mux control, 0=requester 0, 1=requester 1.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 IDLE: when either valid is high, grant exactly one requester, assert only its ready for that cycle, latch its a/b through the sel-driven 2:1 mux, record rsp_id, go to EXEC.
REQ-018 reqX_ready SHALL be high only in IDLE and only for the granted requester; it is combinational from valid and arbitration state.
REQ-019 EXEC: register {carry, sum} = a + b at WIDTH+1 bits, then go to RESP.
REQ-020 RESP: hold rsp_valid=1 with stable rsp_sum/rsp_carry/rsp_id until the cycle rsp_ready=1, then go to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from accept edge to rsp_valid; best-case throughput is one result per 3 cycles.
REQ-022 Both valids high in IDLE: grant per REQ-030/031; the loser's ready stays 0 and it is served in a later IDLE.
REQ-023 Requests arriving in EXEC or RESP SHALL wait; no request is dropped or duplicated.
REQ-024 sel SHALL reflect the current grant in IDLE and hold the last grant in EXEC and RESP.
REQ-025 Overflow: 0xFFFFFFFF + 0x00000001 SHALL yield sum 0x00000000, carry 1.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, sel=0, and both readys 0 while asserted.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight transaction without emitting it.
REQ-028 The round-robin pointer SHALL reset to "last grant = 1", so requester 0 wins the first contention.
REQ-029 Release of rst_n SHALL take effect on the next rising clk edge.

Configuration
REQ-030 With UADD_ARB_RR_EN defined: round-robin; on contention grant the requester not granted last; the pointer updates only on accept.
REQ-031 Without UADD_ARB_RR_EN: fixed priority, requester 0 always wins contention; no pointer flop is instantiated.

Structure
REQ-032 Package uadd_arb_pkg SHALL hold the FSM state typedef (IDLE/EXEC/RESP), the WIDTH default constant and the requester-id width constant.
REQ-033 Grant logic SHALL be a sub-module uadd_rr_arbiter (2 requesters, accept strobe in, one-hot grant out), with its pointer under UADD_ARB_RR_EN.

Verification
REQ-034 Single request: req0 a=0x00000005, b=0x00000003 -> req0_ready 1 cycle; 2 cycles later rsp_valid, sum 0x00000008, carry 0, id 0.
REQ-035 Overflow: req1 a=0xFFFFFFFF, b=0x00000001 -> sum 0x00000000, carry 1, id 1, sel=1 held through RESP.
REQ-036 Contention: both valid continuously, rsp_ready=1 -> RR build ids 0,1,0,1; non-RR build ids 0,0,0,0 while req0 stays valid.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, no new ready asserted; rsp_ready=1 -> IDLE next cycle.
REQ-038 Reset in EXEC: rst_n low mid-transaction -> rsp_valid 0 immediately; after release, the next request completes normally with the correct sum.
